escalonador_processos: RTL

Round-robin hardware process scheduler for the multiprogrammed CPU. It keeps a table of up to NUM_PROC processes (active flag plus saved PC) and counts retired instructions against a quantum. On quantum expiry, I/O yield or process end it saves the running PC, picks the next ready process, and sequences the context-switch handshake with the OS switch routine. It sits beside the PC register and drives the process number shown on the process display.

---
 rtl/escalonador_processos.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/escalonador_processos.sv
// Round-robin process scheduler: process table with saved PCs, quantum counter
// and the context-switch handshake with the OS switch routine.
module escalonador_processos #(
    parameter int  NUM_PROC = 8,
    parameter int  QUANTUM  = 16,
    parameter int  PC_W     = 32,
    localparam int IW       = $clog2(NUM_PROC),
    localparam int QW       = $clog2(QUANTUM)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                habilita,
    input  logic                instr_valida,
    input  logic [PC_W-1:0]     pc_atual,
    input  logic                cria_proc,
    input  logic [IW-1:0]       id_cria,
    input  logic [PC_W-1:0]     pc_inicial,
    input  logic                fim_proc,
    input  logic                io_proc,
    input  logic                troca_ack,
    output logic                troca_contexto,
    output logic                carrega_pc,
    output logic [PC_W-1:0]     pc_retorno,
    output logic [IW-1:0]       proc_atual,
    output logic                ocioso,
    output logic [NUM_PROC-1:0] ativos
);

    typedef enum logic [2:0] {
        OCIOSO,
        EXECUTA,
        SALVA,
        SELECIONA,
        AGUARDA_ACK
    } estado_t;

    localparam logic [QW-1:0] Q_ULTIMO = QW'(QUANTUM - 1);

    estado_t         estado, estado_prox;
    logic [QW-1:0]   cont_quantum;
    logic [PC_W-1:0] tabela_pc [NUM_PROC];
    logic            salva_pc;

    logic            em_exec;
    logic            evt_fim, evt_io, evt_expira, conta;
    logic            aceita_cria;
    logic            achou;
    logic [IW-1:0]   proximo, candidato;

    // Round-robin search starting after proc_atual; proc_atual itself is the last candidate.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        achou     = 1'b0;
        proximo   = proc_atual;
        candidato = '0;
        for (int i = 1; i <= NUM_PROC; i++) begin
            candidato = proc_atual + IW'(i);
            if (!achou && ativos[candidato]) begin
                achou   = 1'b1;
                proximo = candidato;
            end
        end
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= OCIOSO;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            estado <= estado_prox;
        end
    end

    // Next-state logic
    always_comb begin
        estado_prox = estado;
        case (estado)
            OCIOSO:      if (habilita && (|ativos)) estado_prox = SELECIONA;
            EXECUTA:     if (evt_fim || evt_io || evt_expira) estado_prox = SALVA;
            SALVA:       estado_prox = SELECIONA;
            SELECIONA:   estado_prox = achou ? AGUARDA_ACK : OCIOSO;
            AGUARDA_ACK: if (troca_ack) estado_prox = EXECUTA;
            default:     estado_prox = OCIOSO;
        endcase
    end

    // Output / control decode; event priority is fim > io > quantum expiry.
    always_comb begin
        ocioso      = (estado == OCIOSO);
        em_exec     = (estado == EXECUTA) && habilita;
        evt_fim     = em_exec && fim_proc;
        evt_io      = em_exec && !fim_proc && io_proc;
        evt_expira  = em_exec && !fim_proc && !io_proc && instr_valida
                      && (cont_quantum == Q_ULTIMO);
        conta       = em_exec && !fim_proc && !io_proc && instr_valida
                      && (cont_quantum != Q_ULTIMO);
        aceita_cria = cria_proc && !ativos[id_cria];
    end

    // Control datapath: active bitmap, quantum, selection and handshake pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ativos         <= '0;
            proc_atual     <= '0;
            cont_quantum   <= '0;
            salva_pc       <= 1'b0;
            troca_contexto <= 1'b0;
            carrega_pc     <= 1'b0;
        end else begin
            if (evt_fim) ativos[proc_atual] <= 1'b0;
            // Checked against the registered bitmap, so an entry being ended this cycle stays ignored.
            if (aceita_cria) ativos[id_cria] <= 1'b1;

            if (estado == EXECUTA) salva_pc <= evt_io || evt_expira;

            if (conta) cont_quantum <= cont_quantum + QW'(1);

            if ((estado == SELECIONA) && achou) begin
                proc_atual   <= proximo;
                cont_quantum <= '0;
            end

            troca_contexto <= (estado == SELECIONA) && achou;
            carrega_pc     <= (estado == AGUARDA_ACK) && troca_ack;
        end
    end

    // Process PC table. Writes never collide: a creation only targets an
    // inactive entry, while the save only targets the running (active) one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: this table is cleared on reset, so it builds from flops, not a RAM macro.
            for (int i = 0; i < NUM_PROC; i++) tabela_pc[i] <= '0;
            pc_retorno <= '0;
        end else begin
            if (aceita_cria) tabela_pc[id_cria] <= pc_inicial;
            if ((estado == SALVA) && salva_pc) tabela_pc[proc_atual] <= pc_atual;
            pc_retorno <= tabela_pc[proc_atual];
        end
    end

    a_troca_pulso: assert property (@(posedge clock) disable iff (reset)
        troca_contexto |=> !troca_contexto);

    a_carrega_executa: assert property (@(posedge clock) disable iff (reset)
        carrega_pc |-> (estado == EXECUTA));

    a_exec_ativo: assert property (@(posedge clock) disable iff (reset)
        (estado == EXECUTA) |-> ativos[proc_atual]);

endmodule
